// File: rtl/eth_pkg.sv
// eth_pkg: constants and transmitter state encoding shared by the
// Ethernet-controller serial link transmitter and receiver.
package eth_pkg;

    localparam int ETH_LEN_W     = 11;
    localparam int ETH_BUF_BYTES = 2048;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_FETCH,
        TX_LOAD,
        TX_SHIFT,
        TX_TAIL,
        TX_DONE
    } eth_tx_state_t;

endpackage

// File: rtl/eth_tx_bitclk.sv
// eth_tx_bitclk: half-period divider producing the link clock level.
// Ports: clk, rst (async high), en (run; low clears to start of a low
// phase), phase (sck level), fall_tick/rise_tick (last clock of the
// high/low half, one cycle wide).
module eth_tx_bitclk #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int            CW   = $clog2(HALF_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap      = en && (cnt == LAST);
    assign rise_tick = wrap && !phase;
    assign fall_tick = wrap && phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/eth_transmitter.sv
// eth_transmitter: serializes one buffered frame per start onto the
// serial link (sck_o/mosi_o/ena_o), bytes from address 0, LSB first.
// Ports: clk, rst (async high); start/tx_len/abort control;
// tx_addr/tx_buf_re/tx_d buffer read port (data one cycle after re);
// sck_o/mosi_o/ena_o link; busy, done pulse, sent_cnt status.
module eth_transmitter
    import eth_pkg::*;
#(
    parameter int HALF_DIV = 4,
    parameter int LEN_W    = ETH_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] tx_len,
    input  logic             abort,
    output logic [LEN_W-1:0] tx_addr,
    output logic             tx_buf_re,
    input  logic [7:0]       tx_d,
    output logic             sck_o,
    output logic             mosi_o,
    output logic             ena_o,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] sent_cnt
);

    eth_tx_state_t    state;
    eth_tx_state_t    state_nx;
    logic [LEN_W-1:0] len_r;
    logic [7:0]       sh_r;
    logic [7:0]       hold_r;
    logic [2:0]       bit_cnt;
    logic             byte_start;
    logic             hold_pend;
    logic             bclk_en;
    logic             phase;
    logic             fall_tick;
    logic             rise_tick;
    logic             in_shift;
    logic             last_byte;
    logic             byte_end;
    logic             prefetch;

    assign in_shift = (state == TX_SHIFT);
    assign bclk_en  = in_shift || (state == TX_TAIL);

    eth_tx_bitclk #(
        .HALF_DIV (HALF_DIV)
    ) u_bitclk (
        .clk       (clk),
        .rst       (rst),
        .en        (bclk_en),
        .phase     (phase),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick)
    );

    // sent_cnt doubles as the index of the byte being shifted
    assign last_byte = (sent_cnt == len_r - LEN_W'(1));
    assign byte_end  = in_shift && fall_tick && (bit_cnt == 3'd7);
    assign prefetch  = in_shift && byte_start && !last_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            TX_IDLE: begin
                if (start) begin
                    state_nx = (tx_len == '0) ? TX_DONE : TX_FETCH;
                end
            end
            TX_FETCH: state_nx = TX_LOAD;
            TX_LOAD:  state_nx = TX_SHIFT;
            TX_SHIFT: begin
                if (byte_end && last_byte) begin
                    state_nx = TX_TAIL;
                end
            end
            TX_TAIL: begin
                if (rise_tick) begin
                    state_nx = TX_DONE;
                end
            end
            TX_DONE:  state_nx = TX_IDLE;
            default:  state_nx = TX_IDLE;
        endcase
        if (abort && (state != TX_IDLE)) begin
            state_nx = TX_IDLE;
        end
    end

    // Datapath is left running on abort; the state gating on the
    // outputs is what silences the link.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r      <= '0;
            sh_r       <= '0;
            hold_r     <= '0;
            bit_cnt    <= '0;
            byte_start <= 1'b0;
            hold_pend  <= 1'b0;
            sent_cnt   <= '0;
        end else begin
            byte_start <= 1'b0;
            hold_pend  <= prefetch;
            if (hold_pend) begin
                hold_r <= tx_d;
            end
            if ((state == TX_IDLE) && start && (tx_len != '0)) begin
                len_r    <= tx_len;
                sent_cnt <= '0;
            end
            if (state == TX_LOAD) begin
                sh_r       <= tx_d;
                bit_cnt    <= '0;
                byte_start <= 1'b1;
            end
            if (in_shift && fall_tick) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    sent_cnt <= sent_cnt + LEN_W'(1);
                    if (!last_byte) begin
                        sh_r       <= hold_r;
                        byte_start <= 1'b1;
                    end
                end else begin
                    sh_r <= {1'b0, sh_r[7:1]};
                end
            end
        end
    end

    assign busy      = (state != TX_IDLE);
    assign done      = (state == TX_DONE);
    assign ena_o     = bclk_en;
    assign sck_o     = in_shift && phase;
    assign mosi_o    = in_shift && sh_r[0];
    assign tx_buf_re = (state == TX_FETCH) || prefetch;
    assign tx_addr   = prefetch ? (sent_cnt + LEN_W'(1)) : '0;

endmodule

// File: tb/tb_eth_transmitter.sv
// tb_eth_transmitter: directed bench for eth_transmitter, two instances
// (HALF_DIV=2 and HALF_DIV=1) with buffer models and a link receiver.
module tb_eth_transmitter;
    import eth_pkg::*;

    localparam int LW = ETH_LEN_W;
    localparam int NB = 20000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start[2];
    logic          abort[2];
    logic [LW-1:0] tx_len[2];
    logic [LW-1:0] addr[2];
    logic          re[2];
    logic [7:0]    tx_d[2];
    logic          sck[2];
    logic          mosi[2];
    logic          ena[2];
    logic          busy[2];
    logic          done[2];
    logic [LW-1:0] sent[2];

    logic [7:0] mem[2][ETH_BUF_BYTES];
    int         rd_cnt[2][ETH_BUF_BYTES];
    int         rd_base[ETH_BUF_BYTES];
    int         rd_tot[2];
    int         rise_n[2];
    int         ena_n[2];
    int         done_n[2];
    int         gap_bad[2];
    int         stray[2];
    int         rx_n[2];
    int         bit_n[2];
    logic [7:0] rx_b[2][4096];
    bit         rx_bits[2][NB];
    bit         sck_q[2];
    bit         lr_ok[2];
    int         rbit[2];
    int         last_rise[2];
    logic [7:0] rsh[2];
    int         cyc;

    int n_cmp;
    int n_bad;
    int s_rise, s_ena, s_done, s_rd, s_gap, s_rx, s_bit;

    eth_transmitter #(.HALF_DIV(2), .LEN_W(LW)) u_dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .tx_len(tx_len[0]),
        .abort(abort[0]), .tx_addr(addr[0]), .tx_buf_re(re[0]),
        .tx_d(tx_d[0]), .sck_o(sck[0]), .mosi_o(mosi[0]),
        .ena_o(ena[0]), .busy(busy[0]), .done(done[0]),
        .sent_cnt(sent[0])
    );

    eth_transmitter #(.HALF_DIV(1), .LEN_W(LW)) u_dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .tx_len(tx_len[1]),
        .abort(abort[1]), .tx_addr(addr[1]), .tx_buf_re(re[1]),
        .tx_d(tx_d[1]), .sck_o(sck[1]), .mosi_o(mosi[1]),
        .ena_o(ena[1]), .busy(busy[1]), .done(done[1]),
        .sent_cnt(sent[1])
    );

    function automatic int hd(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    // transmit buffer: synchronous read, data the cycle after re
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (re[g]) begin
                tx_d[g] <= mem[g][addr[g]];
                rd_cnt[g][addr[g]]++;
                rd_tot[g]++;
            end
        end
    end

    // link receiver: samples mosi on each sck rise while ena is high
    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < 2; g++) begin
            if (ena[g]) ena_n[g]++;
            if (done[g]) done_n[g]++;
            if (sck[g] && !ena[g]) stray[g]++;
            if (!ena[g]) begin
                rbit[g]  = 0;
                lr_ok[g] = 1'b0;
            end else if (sck[g] && !sck_q[g]) begin
                rise_n[g]++;
                if (lr_ok[g] && (cyc - last_rise[g] != 2 * hd(g)))
                    gap_bad[g]++;
                last_rise[g] = cyc;
                lr_ok[g]     = 1'b1;
                if (bit_n[g] < NB) rx_bits[g][bit_n[g]] = mosi[g];
                bit_n[g]++;
                rsh[g] = {mosi[g], rsh[g][7:1]};
                rbit[g]++;
                if (rbit[g] == 8) begin
                    if (rx_n[g] < 4096) rx_b[g][rx_n[g]] = rsh[g];
                    rx_n[g]++;
                    rbit[g] = 0;
                end
            end
            sck_q[g] = sck[g];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input int g);
        s_rise = rise_n[g];
        s_ena  = ena_n[g];
        s_done = done_n[g];
        s_rd   = rd_tot[g];
        s_gap  = gap_bad[g];
        s_rx   = rx_n[g];
        s_bit  = bit_n[g];
    endtask

    task automatic send(input int g, input int len);
        int n;
        start[g]  = 1'b1;
        tx_len[g] = LW'(len);
        tick();
        start[g]  = 1'b0;
        n = 0;
        while (!done[g] && n < 16 * hd(g) * len + 50) begin
            tick();
            n++;
        end
        chk("frame_done_seen", 32'(done[g]), 1);
        tick();
    endtask

    logic [15:0] v;
    logic [7:0]  exp4[4];
    int          bad;
    int          n;

    initial begin
        for (int g = 0; g < 2; g++) begin
            start[g]  = 1'b0;
            abort[g]  = 1'b0;
            tx_len[g] = '0;
        end
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        tick();
        tick();
        chk("rst_sck", 32'(sck[0]), 0);
        chk("rst_ena", 32'(ena[0]), 0);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_re", 32'(re[0]), 0);
        chk("rst_addr", 32'(addr[0]), 0);
        chk("rst_sent", 32'(sent[0]), 0);
        rst = 1'b0;
        tick();

        // 1: HALF_DIV=2, two bytes
        mem[0][0] = 8'hA5;
        mem[0][1] = 8'h3C;
        snap(0);
        send(0, 2);
        v = '0;
        for (int i = 0; i < 16; i++) v = {v[14:0], rx_bits[0][s_bit + i]};
        chk("t1_mosi_bits", 32'(v), 32'hA53C);
        chk("t1_rises", rise_n[0] - s_rise, 16);
        chk("t1_ena_clocks", ena_n[0] - s_ena, 66);
        chk("t1_done_pulses", done_n[0] - s_done, 1);
        chk("t1_sent", 32'(sent[0]), 2);
        chk("t1_reads", rd_tot[0] - s_rd, 2);
        chk("t1_idle_busy", 32'(busy[0]), 0);

        // 3: zero-length frame
        snap(0);
        start[0]  = 1'b1;
        tx_len[0] = '0;
        tick();
        start[0]  = 1'b0;
        chk("t3_done_next", 32'(done[0]), 1);
        tick();
        chk("t3_done_one", 32'(done[0]), 0);
        repeat (4) tick();
        chk("t3_ena", ena_n[0] - s_ena, 0);
        chk("t3_rises", rise_n[0] - s_rise, 0);
        chk("t3_reads", rd_tot[0] - s_rd, 0);
        chk("t3_done_pulses", done_n[0] - s_done, 1);

        // 4: abort in bit 3 of byte 1, then a full frame
        mem[0][0] = 8'h11;
        mem[0][1] = 8'h22;
        mem[0][2] = 8'h33;
        snap(0);
        start[0]  = 1'b1;
        tx_len[0] = LW'(3);
        tick();
        start[0]  = 1'b0;
        n = 0;
        while (rise_n[0] - s_rise < 12 && n < 200) begin
            tick();
            n++;
        end
        chk("t4_reach_bit3", 32'(rise_n[0] - s_rise >= 12), 1);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("t4_ena", 32'(ena[0]), 0);
        chk("t4_sck", 32'(sck[0]), 0);
        chk("t4_busy", 32'(busy[0]), 0);
        chk("t4_done", 32'(done[0]), 0);
        chk("t4_sent", 32'(sent[0]), 1);
        repeat (5) tick();
        chk("t4_no_done", done_n[0] - s_done, 0);
        snap(0);
        send(0, 3);
        chk("t4_b0", 32'(rx_b[0][s_rx]), 32'h11);
        chk("t4_b1", 32'(rx_b[0][s_rx + 1]), 32'h22);
        chk("t4_b2", 32'(rx_b[0][s_rx + 2]), 32'h33);
        chk("t4_sent_full", 32'(sent[0]), 3);
        chk("t4_done_full", done_n[0] - s_done, 1);

        // 5: extra starts ignored, then rst mid-byte
        mem[0][0] = 8'hC3;
        mem[0][1] = 8'h5A;
        snap(0);
        start[0]  = 1'b1;
        tx_len[0] = LW'(2);
        tick();
        start[0]  = 1'b0;
        repeat (3) tick();
        start[0]  = 1'b1;
        tx_len[0] = LW'(1);
        tick();
        start[0]  = 1'b0;
        repeat (20) tick();
        start[0]  = 1'b1;
        tick();
        start[0]  = 1'b0;
        n = 0;
        while (!done[0] && n < 200) begin
            tick();
            n++;
        end
        chk("t5_done_seen", 32'(done[0]), 1);
        tick();
        chk("t5_sent", 32'(sent[0]), 2);
        chk("t5_rises", rise_n[0] - s_rise, 16);
        chk("t5_b0", 32'(rx_b[0][s_rx]), 32'hC3);
        chk("t5_b1", 32'(rx_b[0][s_rx + 1]), 32'h5A);
        chk("t5_done_pulses", done_n[0] - s_done, 1);
        start[0]  = 1'b1;
        tx_len[0] = LW'(2);
        tick();
        start[0]  = 1'b0;
        repeat (10) tick();
        chk("t5_pre_rst_ena", 32'(ena[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_sck", 32'(sck[0]), 0);
        chk("t5_rst_mosi", 32'(mosi[0]), 0);
        chk("t5_rst_ena", 32'(ena[0]), 0);
        chk("t5_rst_busy", 32'(busy[0]), 0);
        chk("t5_rst_done", 32'(done[0]), 0);
        chk("t5_rst_re", 32'(re[0]), 0);
        chk("t5_rst_addr", 32'(addr[0]), 0);
        chk("t5_rst_sent", 32'(sent[0]), 0);
        tick();
        rst = 1'b0;
        tick();

        // 2: HALF_DIV=1 loopback
        exp4[0] = 8'h00;
        exp4[1] = 8'hFF;
        exp4[2] = 8'h55;
        exp4[3] = 8'h81;
        for (int i = 0; i < 4; i++) mem[1][i] = exp4[i];
        snap(1);
        send(1, 4);
        chk("t2_rx_count", rx_n[1] - s_rx, 4);
        for (int i = 0; i < 4; i++)
            chk("t2_rx_byte", 32'(rx_b[1][s_rx + i]), 32'(exp4[i]));
        chk("t2_sck_gaps", gap_bad[1] - s_gap, 0);
        chk("t2_ena_clocks", ena_n[1] - s_ena, 65);
        chk("t2_sent", 32'(sent[1]), 4);

        // 6: maximum length
        for (int a = 0; a < ETH_BUF_BYTES; a++) begin
            mem[1][a]  = 8'($urandom);
            rd_base[a] = rd_cnt[1][a];
        end
        snap(1);
        send(1, 2047);
        bad = 0;
        for (int a = 0; a < ETH_BUF_BYTES; a++)
            if (rd_cnt[1][a] - rd_base[a] != ((a < 2047) ? 1 : 0)) bad++;
        chk("t6_read_once", bad, 0);
        chk("t6_reads", rd_tot[1] - s_rd, 2047);
        bad = 0;
        for (int i = 0; i < 2047; i++)
            if (rx_b[1][s_rx + i] !== mem[1][i]) bad++;
        chk("t6_rx_bytes", bad, 0);
        chk("t6_rx_count", rx_n[1] - s_rx, 2047);
        chk("t6_rises", rise_n[1] - s_rise, 16376);
        chk("t6_ena_clocks", ena_n[1] - s_ena, 32753);
        chk("t6_sent", 32'(sent[1]), 2047);
        chk("t6_done_pulses", done_n[1] - s_done, 1);
        chk("t6_sck_gaps", gap_bad[1] - s_gap, 0);

        chk("stray_sck_a", stray[0], 0);
        chk("stray_sck_b", stray[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
